// File: rtl/spi_slave_engine_if.sv
// ============================================================================
// Module      : spi_slave_engine_if
// Description : Control, serial-pin and user-side signals of the SPI slave engine
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface spi_slave_engine_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  SPE;
   logic                  CPOL;
   logic                  CPHA;
   logic                  LSBFE;
   logic                  SS_slave;
   logic                  SCK_in;
   logic                  MOSI_in;
   logic                  MISO_out;
   logic                  MISO_oe;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_wr;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  SPIF;
   logic                  spif_clr;
   logic                  busy;
   logic                  overrun;

   modport slave (
      input  SPE, CPOL, CPHA, LSBFE, SS_slave, SCK_in, MOSI_in, tx_data, tx_wr, spif_clr,
      output MISO_out, MISO_oe, rx_data, SPIF, busy, overrun
   );

   modport master (
      output SPE, CPOL, CPHA, LSBFE, SS_slave, SCK_in, MOSI_in, tx_data, tx_wr, spif_clr,
      input  MISO_out, MISO_oe, rx_data, SPIF, busy, overrun
   );
endinterface

`default_nettype wire

// File: rtl/spi_slave_engine.sv
// ============================================================================
// Module      : spi_slave_engine
// Description : Oversampling SPI slave, all CPOL/CPHA modes, MSB/LSB first.
//               Optional receive-overrun tracking via SPI_SLAVE_OVERRUN_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_slave_engine #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_WIDTH  = 8
) (
   input  wire logic         clk,
   input  wire logic         rst,
   spi_slave_engine_if.slave bus
);
   localparam int                c_CW   = $clog2(DATA_WIDTH) + 1;
   localparam logic [c_CW-1:0]   c_FULL = c_CW'(DATA_WIDTH);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;
   state_t r_state, w_state_nxt;

   logic [SYNC_STAGES-1:0] r_ss_sync, r_sck_sync, r_mosi_sync;
   logic                   r_ss_d, r_sck_d;
   logic [c_CW-1:0]        r_bit_cnt;
   logic [DATA_WIDTH-1:0]  r_tx_shift, r_rx_shift, r_tx_buf, r_rx_data;
   logic                   r_spif, r_edge_seen;
   logic                   w_ss_s, w_sck_s, w_mosi_s;
   logic                   w_lead, w_trail, w_enter, w_exit, w_done, w_sample, w_shift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ss_sync   <= '1;
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_ss_d      <= 1'b1;
         r_sck_d     <= 1'b0;
      end else begin
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.SS_slave};
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.SCK_in};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI_in};
         r_ss_d      <= w_ss_s;
         r_sck_d     <= w_sck_s;
      end
   end

   assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
   assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
   assign w_lead   = (w_sck_s != r_sck_d) && (w_sck_s != bus.CPOL);
   assign w_trail  = (w_sck_s != r_sck_d) && (w_sck_s == bus.CPOL);
   assign w_enter  = bus.SPE && r_ss_d && !w_ss_s;
   assign w_exit   = !bus.SPE || w_ss_s;
   assign w_done   = (r_state == S_ACTIVE) && (r_bit_cnt == c_FULL);
   assign w_sample = (r_state == S_ACTIVE) && !w_exit && !w_done && (bus.CPHA ? w_trail : w_lead);
   // No shift before the first sample of a byte: the loaded MSB/LSB is already on MISO
   assign w_shift  = (r_state == S_ACTIVE) && !w_exit && !w_done && (r_bit_cnt != '0)
                     && (bus.CPHA ? w_lead : w_trail);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      bus.MISO_oe  = 1'b0;
      bus.busy     = 1'b0;
      bus.MISO_out = 1'b1;
      case (r_state)
         S_IDLE:   if (w_enter) w_state_nxt = S_ACTIVE;
         S_ACTIVE: begin
            if (w_exit) w_state_nxt = S_IDLE;
            bus.MISO_oe  = 1'b1;
            bus.busy     = (r_bit_cnt != '0) || r_edge_seen;
            bus.MISO_out = bus.LSBFE ? r_tx_shift[0] : r_tx_shift[DATA_WIDTH-1];
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt   <= '0;
         r_tx_shift  <= '0;
         r_rx_shift  <= '0;
         r_tx_buf    <= '1;
         r_edge_seen <= 1'b0;
      end else begin
         if (bus.tx_wr) r_tx_buf <= bus.tx_data;
         if (r_state == S_IDLE) begin
            r_edge_seen <= 1'b0;
            if (w_enter) begin
               r_tx_shift <= r_tx_buf;
               r_bit_cnt  <= '0;
            end
         end else if (w_done) begin
            r_bit_cnt   <= '0;
            r_edge_seen <= 1'b0;
            r_tx_shift  <= r_tx_buf;
         end else if (w_exit) begin
            r_bit_cnt   <= '0;
            r_edge_seen <= 1'b0;
         end else begin
            if (w_lead) r_edge_seen <= 1'b1;
            if (w_sample) begin
               r_bit_cnt  <= r_bit_cnt + c_CW'(1);
               r_rx_shift <= bus.LSBFE ? {w_mosi_s, r_rx_shift[DATA_WIDTH-1:1]}
                                       : {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
            end
            if (w_shift) begin
               r_tx_shift <= bus.LSBFE ? {1'b0, r_tx_shift[DATA_WIDTH-1:1]}
                                       : {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
         end
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   logic r_overrun;

   // A clear arriving with a completion lets the new byte in without touching overrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_data <= '0;
         r_spif    <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_done) begin
         if (bus.spif_clr || !r_spif) r_rx_data <= r_rx_shift;
         else                         r_overrun <= 1'b1;
         r_spif <= 1'b1;
      end else if (bus.spif_clr) begin
         r_spif    <= 1'b0;
         r_overrun <= 1'b0;
      end
   end

   assign bus.overrun = r_overrun;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_data <= '0;
         r_spif    <= 1'b0;
      end else if (w_done) begin
         r_rx_data <= r_rx_shift;
         r_spif    <= 1'b1;
      end else if (bus.spif_clr) begin
         r_spif    <= 1'b0;
      end
   end

   assign bus.overrun = 1'b0;
`endif

   assign bus.rx_data = r_rx_data;
   assign bus.SPIF    = r_spif;
endmodule

`default_nettype wire

// File: tb/tb_spi_slave_engine.sv
// ============================================================================
// Module      : tb_spi_slave_engine
// Description : Directed self-checking bench; acts as SPI master and user side.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_engine;
   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] mi;

   spi_slave_engine_if #(.DATA_WIDTH(8)) bus ();

   spi_slave_engine #(.SYNC_STAGES(2), .DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_tx(input logic [7:0] v);
      bus.tx_data = v;
      bus.tx_wr   = 1'b1;
      wait_clk(1);
      bus.tx_wr   = 1'b0;
   endtask

   task automatic clr_spif();
      bus.spif_clr = 1'b1;
      wait_clk(1);
      bus.spif_clr = 1'b0;
   endtask

   // Master side of one byte; optionally checks SPIF latency and writes tx_buf mid-byte
   task automatic xfer(input logic [7:0] mo, input int nbits, input bit chk_lat,
                       input int wr_at, input logic [7:0] wr_val, output logic [7:0] got);
      int idx;
      got = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         idx = bus.LSBFE ? i : 7 - i;
         if (!bus.CPHA) begin
            bus.MOSI_in = mo[idx];
            if (i == wr_at) begin
               write_tx(wr_val);
               wait_clk(HALF - 1);
            end else begin
               wait_clk(HALF);
            end
            got[idx]   = bus.MISO_out;
            bus.SCK_in = ~bus.CPOL;
            if (chk_lat && i == nbits - 1) begin
               wait_clk(3);
               check("spif_latency_early", {31'd0, bus.SPIF}, 32'd0);
               wait_clk(1);
               check("spif_latency_rise", {31'd0, bus.SPIF}, 32'd1);
               wait_clk(HALF - 4);
            end else begin
               wait_clk(HALF);
            end
            bus.SCK_in = bus.CPOL;
         end else begin
            wait_clk(HALF);
            bus.SCK_in  = ~bus.CPOL;
            bus.MOSI_in = mo[idx];
            wait_clk(HALF);
            got[idx]   = bus.MISO_out;
            bus.SCK_in = bus.CPOL;
         end
      end
      wait_clk(HALF);
   endtask

   initial begin
      rst = 1'b1;
      bus.SPE = 1'b0; bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.LSBFE = 1'b0;
      bus.SS_slave = 1'b1; bus.SCK_in = 1'b0; bus.MOSI_in = 1'b0;
      bus.tx_data = 8'h00; bus.tx_wr = 1'b0; bus.spif_clr = 1'b0;
      wait_clk(3);
      check("rst_miso_out", {31'd0, bus.MISO_out}, 32'd1);
      check("rst_miso_oe",  {31'd0, bus.MISO_oe},  32'd0);
      check("rst_spif",     {31'd0, bus.SPIF},     32'd0);
      check("rst_busy",     {31'd0, bus.busy},     32'd0);
      check("rst_rx_data",  {24'd0, bus.rx_data},  32'h00);
      check("rst_overrun",  {31'd0, bus.overrun},  32'd0);
      rst = 1'b0;
      wait_clk(2);

      // Mode 0, MSB first
      bus.SPE = 1'b1;
      write_tx(8'h3C);
      bus.SS_slave = 1'b0;
      wait_clk(HALF);
      check("m0_oe_active",  {31'd0, bus.MISO_oe}, 32'd1);
      check("m0_busy_start", {31'd0, bus.busy},    32'd0);
      xfer(8'hA5, 8, 1'b1, -1, 8'h00, mi);
      check("m0_miso_byte", {24'd0, mi},          32'h3C);
      check("m0_rx_data",   {24'd0, bus.rx_data}, 32'hA5);
      bus.SS_slave = 1'b1;
      wait_clk(HALF);
      check("m0_oe_idle",   {31'd0, bus.MISO_oe}, 32'd0);
      check("m0_busy_idle", {31'd0, bus.busy},    32'd0);
      clr_spif();
      check("m0_spif_clr",  {31'd0, bus.SPIF},    32'd0);

      // Mode 3, LSB first
      bus.CPOL = 1'b1; bus.SCK_in = 1'b1; bus.CPHA = 1'b1; bus.LSBFE = 1'b1;
      wait_clk(4);
      write_tx(8'h81);
      bus.SS_slave = 1'b0;
      wait_clk(HALF);
      xfer(8'h0F, 8, 1'b0, -1, 8'h00, mi);
      check("m3_miso_byte", {24'd0, mi},          32'h81);
      check("m3_rx_data",   {24'd0, bus.rx_data}, 32'h0F);
      check("m3_spif",      {31'd0, bus.SPIF},    32'd1);
      bus.SS_slave = 1'b1;
      wait_clk(HALF);
      clr_spif();

      // Partial byte aborted, then a full byte
      bus.CPOL = 1'b0; bus.SCK_in = 1'b0; bus.CPHA = 1'b0; bus.LSBFE = 1'b0;
      wait_clk(4);
      bus.SS_slave = 1'b0;
      wait_clk(HALF);
      xfer(8'hFF, 4, 1'b0, -1, 8'h00, mi);
      check("part_busy_mid", {31'd0, bus.busy}, 32'd1);
      bus.SS_slave = 1'b1;
      wait_clk(HALF);
      check("part_no_spif",  {31'd0, bus.SPIF},    32'd0);
      check("part_rx_keep",  {24'd0, bus.rx_data}, 32'h0F);
      check("part_busy_gap", {31'd0, bus.busy},    32'd0);
      bus.SS_slave = 1'b0;
      wait_clk(HALF);
      xfer(8'h5A, 8, 1'b0, -1, 8'h00, mi);
      check("full_miso_byte", {24'd0, mi},          32'h81);
      check("full_rx_data",   {24'd0, bus.rx_data}, 32'h5A);
      check("full_spif",      {31'd0, bus.SPIF},    32'd1);
      bus.SS_slave = 1'b1;
      wait_clk(HALF);
      clr_spif();

      // Back-to-back bytes with tx_buf rewritten during the first
      write_tx(8'h66);
      bus.SS_slave = 1'b0;
      wait_clk(HALF);
      xfer(8'h11, 8, 1'b0, 3, 8'h99, mi);
      check("b2b_miso_1", {24'd0, mi},          32'h66);
      check("b2b_rx_1",   {24'd0, bus.rx_data}, 32'h11);
      check("b2b_spif_1", {31'd0, bus.SPIF},    32'd1);
      clr_spif();
      check("b2b_spif_clr", {31'd0, bus.SPIF},  32'd0);
      xfer(8'h22, 8, 1'b0, -1, 8'h00, mi);
      check("b2b_miso_2", {24'd0, mi},          32'h99);
      check("b2b_rx_2",   {24'd0, bus.rx_data}, 32'h22);
      check("b2b_spif_2", {31'd0, bus.SPIF},    32'd1);
      bus.SS_slave = 1'b1;
      wait_clk(HALF);

      // Another byte with SPIF still set
      bus.SS_slave = 1'b0;
      wait_clk(HALF);
      xfer(8'h77, 8, 1'b0, -1, 8'h00, mi);
      bus.SS_slave = 1'b1;
      wait_clk(HALF);
      check("ovr_spif", {31'd0, bus.SPIF}, 32'd1);
`ifdef SPI_SLAVE_OVERRUN_EN
      check("ovr_flag",    {31'd0, bus.overrun}, 32'd1);
      check("ovr_rx_keep", {24'd0, bus.rx_data}, 32'h22);
      clr_spif();
      check("ovr_clr_flag", {31'd0, bus.overrun}, 32'd0);
`else
      check("ovr_flag",    {31'd0, bus.overrun}, 32'd0);
      check("ovr_rx_new",  {24'd0, bus.rx_data}, 32'h77);
      clr_spif();
`endif
      check("ovr_clr_spif", {31'd0, bus.SPIF}, 32'd0);

      // Reset mid-byte, then SPE low while SS low
      bus.SS_slave = 1'b0;
      wait_clk(HALF);
      xfer(8'hC3, 3, 1'b0, -1, 8'h00, mi);
      check("rst_mid_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      wait_clk(1);
      check("rst_mid_oe",   {31'd0, bus.MISO_oe},  32'd0);
      check("rst_mid_miso", {31'd0, bus.MISO_out}, 32'd1);
      check("rst_mid_busy0",{31'd0, bus.busy},     32'd0);
      check("rst_mid_rx",   {24'd0, bus.rx_data},  32'h00);
      rst = 1'b0;
      bus.SPE = 1'b0;
      wait_clk(HALF);
      check("spe0_oe",   {31'd0, bus.MISO_oe},  32'd0);
      check("spe0_busy", {31'd0, bus.busy},     32'd0);
      check("spe0_miso", {31'd0, bus.MISO_out}, 32'd1);
      check("spe0_spif", {31'd0, bus.SPIF},     32'd0);
      bus.SS_slave = 1'b1;
      wait_clk(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/spi_slave_engine.md
Name: spi_slave_engine

Overview:
- Slave-side SPI responder: the other end of the link driven by the master controller, BRG and SCK control path.
- Runs on the system clock and oversamples the external SS, SCK and MOSI pins through synchronizers.
- Shifts one byte in on MOSI while shifting one byte out on MISO, for all four CPOL/CPHA modes, with MSB-first or LSB-first order.
- Reports completion through a SPIF flag and holds the received byte for the user.

Parameters:
- SYNC_STAGES, 2: flops in each input synchronizer (SS, SCK, MOSI); legal range 2..4.
- DATA_WIDTH, 8: bits per transfer; bit counter width is clog2(DATA_WIDTH)+1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- SPE  in  1  SPI enable, from SPCR
- CPOL  in  1  clock polarity, from SPCR
- CPHA  in  1  clock phase, from SPCR
- LSBFE  in  1  1 = LSB first
- SS_slave  in  1  slave select from port control logic, active low
- SCK_in  in  1  serial clock from port control logic
- MOSI_in  in  1  serial data in
- MISO_out  out  1  serial data out
- MISO_oe  out  1  MISO output enable
- tx_data  in  DATA_WIDTH  byte to transmit
- tx_wr  in  1  one-cycle strobe that loads tx_data into tx_buf
- rx_data  out  DATA_WIDTH  last received byte
- SPIF  out  1  transfer-complete flag, sticky
- spif_clr  in  1  one-cycle SPIF clear
- busy  out  1  byte in progress
- overrun  out  1  receive overrun, sticky (optional feature)

Behaviour:
- Reset values:
  - synchronizers: SS = 1, SCK = 0, MOSI = 0
  - state = IDLE, bit_cnt = 0, shift registers = 0, tx_buf = 0xFF
  - all outputs 0 except MISO_out = 1
- Edge detection:
  - Synchronized SCK is registered once more to form sck_d.
  - Leading edge: sck_s != sck_d and sck_s != CPOL.
  - Trailing edge: sck_s != sck_d and sck_s == CPOL.
- Edge roles:
  - CPHA = 0: sample on leading edge, shift on trailing edge; the first bit is presented on MISO when IDLE exits.
  - CPHA = 1: shift on leading edge, sample on trailing edge.
- Timing constraint: each SCK half period must be at least SYNC_STAGES+2 clk cycles. Faster SCK is unsupported and its behaviour is undefined.
- States:
  - IDLE: SPE = 0 or ss_s = 1. MISO_oe = 0, busy = 0.
  - IDLE -> ACTIVE: SPE = 1 and ss_s falls. Load tx_shift <= tx_buf, clear bit_cnt.
  - ACTIVE: MISO_oe = 1.
    - busy = 1 while bit_cnt != 0, or after the first SCK edge.
    - MISO_out = tx_shift MSB (LSBFE = 0) or LSB (LSBFE = 1).
    - Sample edge: MOSI bit enters rx_shift (LSB end if MSB-first, MSB end if LSB-first); bit_cnt++.
    - Shift edge: tx_shift shifts toward the output bit.
    - In CPHA = 0, the shift edge after the final sample is ignored.
  - Byte completion, when bit_cnt reaches DATA_WIDTH on a sample edge:
    - Next clk: rx_data <= assembled byte, SPIF <= 1, bit_cnt <= 0.
    - tx_shift <= tx_buf, supporting a back-to-back byte while SS stays low. State remains ACTIVE.
  - ACTIVE -> IDLE when ss_s rises or SPE drops:
    - A partial byte is discarded: bit_cnt = 0, no SPIF, rx_data unchanged.
    - Takes effect the same cycle the condition is seen.
- tx_wr:
  - Updates tx_buf at any time.
  - A write mid-byte does not disturb tx_shift; it is used at the next load.
- SPIF:
  - Set by byte completion; cleared by spif_clr.
  - Set and clear in the same cycle: set wins.
- Latency: SPIF rises SYNC_STAGES+2 clk after the final sampling SCK edge at the pin.
- Reset asserted mid-operation: everything returns to reset values immediately.
- SPE changes: CPOL, CPHA and LSBFE may only change while IDLE.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- Defined:
  - Byte completion while SPIF = 1 sets overrun (sticky) and leaves rx_data holding the old byte.
  - spif_clr clears both SPIF and overrun.
  - If completion and spif_clr occur in the same cycle, the new byte is accepted, SPIF = 1 and overrun is unchanged.
- Undefined: overrun is tied to 0 and rx_data is always overwritten on completion.

Test Plan:
- Mode 0, MSB first, tx_wr 0x3C, master sends 0xA5 -> MISO bits 0,0,1,1,1,1,0,0; rx_data = 0xA5; SPIF = 1 SYNC_STAGES+2 clk after the 8th rising SCK edge.
- Mode 3, LSBFE = 1, tx 0x81, master sends 0x0F -> MISO LSB first 1,0,0,0,0,0,0,1; rx_data = 0x0F.
- SS raised after 4 bits of 0xFF, then a full transfer of 0x5A -> no SPIF after the partial byte; rx_data = 0x5A after the full one; busy = 0 between them.
- Back-to-back 0x11 then 0x22 with SS held low, tx_wr 0x99 mid-first-byte -> second MISO byte = 0x99; rx_data = 0x22; SPIF set after each byte.
- SPIF never cleared, second byte 0x77 arrives -> with SPI_SLAVE_OVERRUN_EN: overrun = 1, rx_data keeps the first byte; without it: rx_data = 0x77.
- rst pulsed mid-byte, then SPE = 0 while SS is low -> all outputs return to reset values; MISO_oe stays 0.
